// File: rtl/fp32_norm_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp32_norm_seq
// Purpose  : Multi-cycle normalizer for the FP32 adder post-add path. Scans the
//            significand one byte per cycle with a shared 8-bit LZC, then
//            shifts the significand left and adjusts the exponent.
// Revision : 1.0
// ============================================================================
module fp32_norm_seq #(
    parameter int EXP_W      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [27:0]      in_sig,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [27:0]      out_sig,
    output logic [EXP_W-1:0] out_exp,
    output logic [4:0]       out_lz,
    output logic             out_zero,
    output logic             out_uflow
);

    localparam int         CMP_W   = (EXP_W > 5) ? EXP_W : 5;
    localparam logic [4:0] LZ_ZERO = 5'd28;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [27:0]        sig_q;
    logic [EXP_W-1:0]   exp_q;
    logic [1:0]         k_q;
    logic [4:0]         lz_q;
    logic               found_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [27:0]        out_sig_q;
    logic [EXP_W-1:0]   out_exp_q;
    logic [4:0]         out_lz_q;
    logic               out_zero_q;
    logic               out_uflow_q;

    logic [7:0]         chunk_d;
    logic [3:0]         clz_d;
    logic [4:0]         chunk_lz_d;
    logic               chunk_hit_d;
    logic [CMP_W-1:0]   lz_ext_d;
    logic [CMP_W-1:0]   exp_ext_d;
    logic [CMP_W-1:0]   amt_d;
    logic [27:0]        shifted_d;
    logic [EXP_W-1:0]   res_exp_d;
    logic               uflow_d;
    logic               scan_end_d;

    function automatic logic [3:0] clz8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) n = 4'(7 - i);
        end
        return n;
    endfunction

    // The last chunk only has four real bits; padding with zeros keeps lz <= 27.
    always_comb begin
        chunk_d = 8'h00;
        case (k_q)
            2'd0:    chunk_d = sig_q[27:20];
            2'd1:    chunk_d = sig_q[19:12];
            2'd2:    chunk_d = sig_q[11:4];
            default: chunk_d = {sig_q[3:0], 4'b0000};
        endcase
    end

    assign clz_d       = clz8(chunk_d);
    assign chunk_hit_d = |chunk_d;
    assign chunk_lz_d  = {k_q, 3'b000} + {1'b0, clz_d};
    assign scan_end_d  = (k_q == 2'd3) || ((EARLY_EXIT != 0) && chunk_hit_d);

    // Shift saturates at the exponent so the subtraction can never wrap.
    assign lz_ext_d  = CMP_W'(lz_q);
    assign exp_ext_d = CMP_W'(exp_q);
    assign amt_d     = (lz_ext_d < exp_ext_d) ? lz_ext_d : exp_ext_d;
    assign shifted_d = sig_q << amt_d;
    assign res_exp_d = exp_q - amt_d[EXP_W-1:0];
    assign uflow_d   = (lz_ext_d >= exp_ext_d) && found_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sig_q       <= '0;
            exp_q       <= '0;
            k_q         <= '0;
            lz_q        <= '0;
            found_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sig_q   <= '0;
            out_exp_q   <= '0;
            out_lz_q    <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sig_q      <= in_sig;
                        exp_q      <= in_exp;
                        k_q        <= 2'd0;
                        lz_q       <= LZ_ZERO;
                        found_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (chunk_hit_d && !found_q) begin
                        lz_q    <= chunk_lz_d;
                        found_q <= 1'b1;
                    end
                    if (scan_end_d) begin
                        state_q <= S_SHIFT;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                S_SHIFT: begin
                    if (found_q) begin
                        out_sig_q   <= shifted_d;
                        out_exp_q   <= res_exp_d;
                        out_uflow_q <= uflow_d;
                        out_zero_q  <= 1'b0;
                    end else begin
                        out_sig_q   <= '0;
                        out_exp_q   <= '0;
                        out_uflow_q <= 1'b0;
                        out_zero_q  <= 1'b1;
                    end
                    out_lz_q    <= lz_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sig   = out_sig_q;
    assign out_exp   = out_exp_q;
    assign out_lz    = out_lz_q;
    assign out_zero  = out_zero_q;
    assign out_uflow = out_uflow_q;

endmodule
`default_nettype wire
